// File: rtl/bcd_seg_scanner.sv
// Three-digit multiplexed 7-segment scanner fed by a packed BCD word.
// Holds new values in a shadow register and only shows them from the next frame boundary.
module bcd_seg_scanner #(
   parameter int REFRESH_CNT  = 50000,
   parameter int GUARD_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] bcd_in,
   input  logic        bcd_valid,
   input  logic        blank_lz,
   output logic [6:0]  seg,
   output logic [2:0]  an,
   output logic        frame_start
);

   localparam int MAX_PHASE = (REFRESH_CNT > GUARD_CYCLES) ? REFRESH_CNT : GUARD_CYCLES;
   localparam int CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
   localparam bit HAS_GUARD = (GUARD_CYCLES > 0);

   localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(REFRESH_CNT - 1);
   localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(HAS_GUARD ? GUARD_CYCLES - 1 : 0);

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [2:0] AN_OFF  = 3'b111;

   typedef enum logic {
      ST_GUARD,
      ST_DRIVE
   } state_e;

   // Every digit slot opens with this phase; it collapses to DRIVE when there is no guard.
   localparam state_e   FIRST_STATE = HAS_GUARD ? ST_GUARD : ST_DRIVE;
   localparam logic [CNT_W-1:0] FIRST_LOAD = HAS_GUARD ? GUARD_LOAD : DRIVE_LOAD;

   state_e            state_q, state_d;
   logic [1:0]        digit_q, digit_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              started_q, started_d;
   logic [11:0]       disp_q, disp_d;
   logic [11:0]       shadow_q, shadow_d;
   logic              pending_q, pending_d;
   logic [6:0]        seg_q, seg_d;
   logic [2:0]        an_q, an_d;
   logic              frame_start_q, frame_start_d;
   logic              boundary;
   logic [3:0]        nibble;
   logic              blank;

   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   function automatic logic [2:0] anode(input logic [1:0] d);
      logic [2:0] a;
      case (d)
         2'd0:    a = 3'b110;
         2'd1:    a = 3'b101;
         2'd2:    a = 3'b011;
         default: a = AN_OFF;
      endcase
      return a;
   endfunction

   // Scan sequencer. The first edge after reset is treated as a frame boundary so the
   // display restarts cleanly at digit 0 with a frame_start pulse.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d   = state_q;
      digit_d   = digit_q;
      cnt_d     = cnt_q;
      started_d = 1'b1;
      boundary  = 1'b0;

      if (!started_q) begin
         state_d  = FIRST_STATE;
         digit_d  = 2'd0;
         cnt_d    = FIRST_LOAD;
         boundary = 1'b1;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else if (state_q == ST_GUARD) begin
         state_d = ST_DRIVE;
         cnt_d   = DRIVE_LOAD;
      end else begin
         state_d  = FIRST_STATE;
         cnt_d    = FIRST_LOAD;
         digit_d  = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
         boundary = (digit_q == 2'd2);
      end
   end

   // Capture path: strobes always land in the shadow; the display register only moves at
   // a boundary, where a strobe on that very edge bypasses the shadow.
   always_comb begin
      shadow_d  = bcd_valid ? bcd_in : shadow_q;
      pending_d = boundary ? 1'b0 : (pending_q | bcd_valid);
      disp_d    = disp_q;
      if (boundary) begin
         if (bcd_valid) begin
            disp_d = bcd_in;
         end else if (pending_q) begin
            disp_d = shadow_q;
         end
      end
   end

   // Output decode looks ahead at the next digit/state so seg and an are registered and
   // switch together on the phase edge.
   always_comb begin
      case (digit_d)
         2'd0:    nibble = disp_d[3:0];
         2'd1:    nibble = disp_d[7:4];
         2'd2:    nibble = disp_d[11:8];
         default: nibble = 4'hF;
      endcase

      blank = blank_lz &&
              (((digit_d == 2'd2) && (disp_d[11:8] == 4'd0)) ||
               ((digit_d == 2'd1) && (disp_d[11:8] == 4'd0) && (disp_d[7:4] == 4'd0)));

      seg_d         = SEG_OFF;
      an_d          = AN_OFF;
      frame_start_d = boundary;
      if ((state_d == ST_DRIVE) && !blank) begin
         seg_d = decode(nibble);
         an_d  = anode(digit_d);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FIRST_STATE;
         digit_q       <= 2'd0;
         cnt_q         <= '0;
         started_q     <= 1'b0;
         disp_q        <= 12'h000;
         shadow_q      <= 12'h000;
         pending_q     <= 1'b0;
         seg_q         <= SEG_OFF;
         an_q          <= AN_OFF;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         digit_q       <= digit_d;
         cnt_q         <= cnt_d;
         started_q     <= started_d;
         disp_q        <= disp_d;
         shadow_q      <= shadow_d;
         pending_q     <= pending_d;
         seg_q         <= seg_d;
         an_q          <= an_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign seg         = seg_q;
   assign an          = an_q;
   assign frame_start = frame_start_q;

   // At most one anode may ever be active.
   a_anode_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~an_q));

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Directed bench for bcd_seg_scanner with REFRESH_CNT=4, GUARD_CYCLES=1 (15-cycle frames).
// Each frame is checked cycle by cycle as {frame_start, an, seg} against hand-computed values.
module tb_bcd_seg_scanner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] bcd_in;
   logic        bcd_valid;
   logic        blank_lz;
   logic [6:0]  seg;
   logic [2:0]  an;
   logic        frame_start;

   int n_pass  = 0;
   int n_total = 0;

   bcd_seg_scanner #(
      .REFRESH_CNT  (4),
      .GUARD_CYCLES (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bcd_in      (bcd_in),
      .bcd_valid   (bcd_valid),
      .blank_lz    (blank_lz),
      .seg         (seg),
      .an          (an),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got {fs,an,seg}=%h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Called on the first cycle (frame_start) of a frame; leaves the bench on the first
   // cycle of the following frame. Strobes are driven at cycle st1/st2 (-1 = none) and are
   // captured on the following rising edge; cycle 14 therefore hits the boundary edge.
   task automatic expect_frame(input string tag, input logic lz,
                               input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                               input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2,
                               input int st1, input logic [11:0] v1,
                               input int st2, input logic [11:0] v2);
      logic [6:0]  s[3];
      logic [2:0]  a[3];
      logic [10:0] exp;
      s[0] = s0; s[1] = s1; s[2] = s2;
      a[0] = a0; a[1] = a1; a[2] = a2;
      blank_lz = lz;
      for (int k = 0; k < 15; k++) begin
         if (k > 0) step();
         if ((k % 5) == 0) exp = {(k == 0), 3'b111, 7'h7F};
         else              exp = {1'b0, a[k / 5], s[k / 5]};
         check($sformatf("%s k%0d", tag, k), {frame_start, an, seg}, exp);
         if (k == st1) begin
            bcd_valid = 1'b1;
            bcd_in    = v1;
         end else if (k == st2) begin
            bcd_valid = 1'b1;
            bcd_in    = v2;
         end else begin
            bcd_valid = 1'b0;
         end
      end
      step();
      bcd_valid = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      bcd_in    = 12'h000;
      bcd_valid = 1'b0;
      blank_lz  = 1'b0;

      repeat (3) step();
      check("in_reset", {frame_start, an, seg}, {1'b0, 3'b111, 7'h7F});
      rst_n = 1'b1;
      step();

      // Reset frame shows 000; a mid-frame strobe must not disturb the rest of it.
      expect_frame("f1_zero", 1'b0, 7'h40, 7'h40, 7'h40, 3'b110, 3'b101, 3'b011,
                   3, 12'h247, -1, 12'h000);
      // 247 from the next frame; boundary-edge strobe of 005 bypasses the shadow.
      expect_frame("f2_247", 1'b0, 7'h78, 7'h19, 7'h24, 3'b110, 3'b101, 3'b011,
                   14, 12'h005, -1, 12'h000);
      expect_frame("f3_005_lz", 1'b1, 7'h12, 7'h7F, 7'h7F, 3'b110, 3'b111, 3'b111,
                   7, 12'h105, -1, 12'h000);
      expect_frame("f4_105_lz", 1'b1, 7'h12, 7'h40, 7'h79, 3'b110, 3'b101, 3'b011,
                   2, 12'h0A3, -1, 12'h000);
      expect_frame("f5_0a3", 1'b0, 7'h30, 7'h3F, 7'h40, 3'b110, 3'b101, 3'b011,
                   -1, 12'h000, -1, 12'h000);
      // Two strobes mid-frame: frame keeps 0A3, next frame shows only the last (222).
      expect_frame("f6_0a3_lz", 1'b1, 7'h30, 7'h3F, 7'h7F, 3'b110, 3'b101, 3'b111,
                   5, 12'h111, 8, 12'h222);
      expect_frame("f7_222", 1'b0, 7'h24, 7'h24, 7'h24, 3'b110, 3'b101, 3'b011,
                   14, 12'h333, -1, 12'h000);
      expect_frame("f8_333", 1'b0, 7'h30, 7'h30, 7'h30, 3'b110, 3'b101, 3'b011,
                   2, 12'h888, -1, 12'h000);

      // Frame showing 888; leave 777 pending, then reset asynchronously mid tens-DRIVE.
      for (int k = 0; k < 8; k++) begin
         logic [10:0] exp;
         if (k > 0) step();
         if (k == 0)                   exp = {1'b1, 3'b111, 7'h7F};
         else if (k < 5)               exp = {1'b0, 3'b110, 7'h00};
         else if (k == 5)              exp = {1'b0, 3'b111, 7'h7F};
         else                          exp = {1'b0, 3'b101, 7'h00};
         check($sformatf("f9_888 k%0d", k), {frame_start, an, seg}, exp);
         bcd_valid = (k == 1);
         bcd_in    = (k == 1) ? 12'h777 : 12'h000;
      end
      bcd_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1 check("async_rst", {frame_start, an, seg}, {1'b0, 3'b111, 7'h7F});
      repeat (3) step();
      rst_n = 1'b1;
      step();

      expect_frame("post_rst", 1'b0, 7'h40, 7'h40, 7'h40, 3'b110, 3'b101, 3'b011,
                   -1, 12'h000, -1, 12'h000);
      expect_frame("pend_lost", 1'b0, 7'h40, 7'h40, 7'h40, 3'b110, 3'b101, 3'b011,
                   -1, 12'h000, -1, 12'h000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
